// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encodings, {N,Z,C,V} flag indices and divider FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_ORR  = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b100;
  localparam logic [2:0] ALU_SMUL = 3'b101;
  localparam logic [2:0] ALU_UMUL = 3'b110;
  localparam logic [2:0] ALU_DIV  = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Start/busy/done handshake and result bus between the control unit and the divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivZero;
  logic [3:0]       Flags;

  modport master (
    output start, sign, a, b,
    input  busy, done, Quotient, Remainder, DivZero, Flags
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, Quotient, Remainder, DivZero, Flags
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // Shifted remainder can reach 2*divisor, so an extra borrow bit is carried.
  assign shifted  = {rem, dvd_msb};
  assign trial    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit    = ~trial[WIDTH+1];
  assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider with start/busy/done handshake and sign fix-up.
module div_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remout_q, remout_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [3:0]       flags;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .divisor  (divisor_q),
    .next_rem (step_rem),
    .q_bit    (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    divisor_d = divisor_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    quot_d    = quot_q;
    remout_d  = remout_q;
    divzero_d = divzero_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bus.b == '0) begin
            state_d   = DONE;
            quot_d    = '1;
            remout_d  = bus.a;
            divzero_d = 1'b1;
          end else begin
            state_d   = RUN;
            dvd_d     = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
            divisor_d = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
            negq_d    = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negr_d    = bus.sign & bus.a[WIDTH-1];
            rem_d     = '0;
            count_d   = CW'(WIDTH);
          end
        end
      end
      RUN: begin
        rem_d   = step_rem;
        dvd_d   = {dvd_q[WIDTH-2:0], step_qbit};
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        quot_d    = negq_q ? -dvd_q : dvd_q;
        remout_d  = negr_q ? -rem_q : rem_q;
        divzero_d = 1'b0;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      quot_q    <= '0;
      remout_q  <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      divisor_q <= divisor_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      quot_q    <= quot_d;
      remout_q  <= remout_d;
      divzero_q <= divzero_d;
    end
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = quot_q[WIDTH-1];
    flags[FLAG_Z] = (quot_q == '0);
  end

  assign bus.busy      = (state_q == RUN) || (state_q == FIX);
  assign bus.done      = (state_q == DONE);
  assign bus.Quotient  = quot_q;
  assign bus.Remainder = remout_q;
  assign bus.DivZero   = divzero_q;
  assign bus.Flags     = flags;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero, overlap and reset.
module tb_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  int   lat;
  int   bcnt;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Issue one op; lat = edges after the accepting edge until done, bcnt = cycles with busy.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int pulse_at);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sign  = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0000_0003;
    bus.sign  = ~s;
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bcnt++;
      if (lat == pulse_at) begin
        bus.start = 1'b1;
        bus.a     = 32'd50;
        bus.b     = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_q", bus.Quotient, 32'd0);
    chk("rst_r", bus.Remainder, 32'd0);
    chk("rst_dz", {31'b0, bus.DivZero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Unsigned 100/7
    do_op(32'd100, 32'd7, 1'b0, -1);
    chk("u100_7_lat", lat, 32'd33);
    chk("u100_7_busy", bcnt, 32'd33);
    chk("u100_7_q", bus.Quotient, 32'd14);
    chk("u100_7_r", bus.Remainder, 32'd2);
    chk("u100_7_dz", {31'b0, bus.DivZero}, 32'd0);
    chk("u100_7_flags", {28'b0, bus.Flags}, 32'h0);
    idle_cycle();

    // Signed -7/2
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1);
    chk("s_m7_2_q", bus.Quotient, 32'hFFFF_FFFD);
    chk("s_m7_2_r", bus.Remainder, 32'hFFFF_FFFF);
    chk("s_m7_2_flags", {28'b0, bus.Flags}, 32'h8);
    idle_cycle();

    // Divide by zero
    do_op(32'd5, 32'd0, 1'b0, -1);
    chk("dz_lat", lat, 32'd0);
    chk("dz_busy", bcnt, 32'd0);
    chk("dz_busy_now", {31'b0, bus.busy}, 32'd0);
    chk("dz_q", bus.Quotient, 32'hFFFF_FFFF);
    chk("dz_r", bus.Remainder, 32'd5);
    chk("dz_flag", {31'b0, bus.DivZero}, 32'd1);
    chk("dz_flags", {28'b0, bus.Flags}, 32'h8);
    idle_cycle();

    // Signed overflow
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
    chk("ovf_q", bus.Quotient, 32'h8000_0000);
    chk("ovf_r", bus.Remainder, 32'd0);
    chk("ovf_flags", {28'b0, bus.Flags}, 32'h8);
    chk("ovf_dz", {31'b0, bus.DivZero}, 32'd0);
    idle_cycle();

    // Unsigned all-ones / 1
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1);
    chk("umax_q", bus.Quotient, 32'hFFFF_FFFF);
    chk("umax_r", bus.Remainder, 32'd0);
    idle_cycle();

    // Unsigned 0x80000000 / 3, no sign processing
    do_op(32'h8000_0000, 32'd3, 1'b0, -1);
    chk("umsb_q", bus.Quotient, 32'h2AAA_AAAA);
    chk("umsb_r", bus.Remainder, 32'd2);
    idle_cycle();

    // Unsigned 0/9
    do_op(32'd0, 32'd9, 1'b0, -1);
    chk("zero_q", bus.Quotient, 32'd0);
    chk("zero_flags", {28'b0, bus.Flags}, 32'h4);
    idle_cycle();

    // Start while busy is ignored; then back-to-back start in the DONE cycle
    do_op(32'd100, 32'd7, 1'b0, 10);
    chk("ign_lat", lat, 32'd33);
    chk("ign_q", bus.Quotient, 32'd14);
    chk("ign_r", bus.Remainder, 32'd2);
    do_op(32'd50, 32'd5, 1'b0, -1);
    chk("b2b_lat", lat, 32'd33);
    chk("b2b_q", bus.Quotient, 32'd10);
    chk("b2b_r", bus.Remainder, 32'd0);
    idle_cycle();

    // Asynchronous reset mid-operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.sign  = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_done", {31'b0, bus.done}, 32'd0);
    chk("arst_q", bus.Quotient, 32'd0);
    chk("arst_r", bus.Remainder, 32'd0);
    chk("arst_dz", {31'b0, bus.DivZero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(32'd9, 32'd3, 1'b0, -1);
    chk("post_rst_lat", lat, 32'd33);
    chk("post_rst_q", bus.Quotient, 32'd3);
    chk("post_rst_r", bus.Remainder, 32'd0);
    idle_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
